uart_tx_arbiter: RTL

Packet-level round-robin arbiter that shares one UART transmitter between `NUM_CHANNELS` byte-stream requesters. It sits directly in front of the UART transmitter and drives its byte/request interface. It watches the transmitter's busy flag and holds a grant for a whole packet, from first byte through the byte flagged `last`. Optionally, it prefixes each packet with a channel-ID header byte.

---
 rtl/uart_tx_arb_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_priority_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

  localparam int UART_TX_ARB_MIN_CHANNELS = 2;
  localparam int UART_TX_ARB_MAX_CHANNELS = 8;
  localparam logic [7:0] UART_TX_ARB_HDR_FLAG = 8'h80;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    HEADER      = 3'd1,
    ISSUE       = 3'd2,
    WAIT_ACCEPT = 3'd3,
    WAIT_DONE   = 3'd4,
    HOLD        = 3'd5
  } arb_state_e;

  function automatic logic [7:0] hdr_byte(input logic [2:0] channel);
    return UART_TX_ARB_HDR_FLAG | {5'd0, channel};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first valid index after last_granted, wrapping.
module rr_priority_picker #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] i_valid,
  input  logic [CH_W-1:0]         i_last_granted,
  output logic                    o_found,
  output logic [CH_W-1:0]         o_idx
);

  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_CHANNELS;
    return CH_W'(s);
  endfunction

  // Offset 1 is checked first, so last_granted itself has lowest priority.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      if (!o_found && i_valid[wrap_idx(i_last_granted, i)]) begin
        o_found = 1'b1;
        o_idx   = wrap_idx(i_last_granted, i);
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter between requesters.
// Define UART_TX_ARB_CHANNEL_ID_EN to prefix each packet with an 8'h80|channel header byte.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W = $clog2(NUM_CHANNELS)
) (
  input  logic                      i_master_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_CHANNELS-1:0]   i_req_valid,
  input  logic [8*NUM_CHANNELS-1:0] i_req_data,
  input  logic [NUM_CHANNELS-1:0]   i_req_last,
  output logic [NUM_CHANNELS-1:0]   o_req_ready,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_data_request,
  input  logic                      i_tx_busy,
  output logic                      o_grant_valid,
  output logic [CH_W-1:0]           o_grant_channel
);

  arb_state_e              state_q, state_d;
  logic [CH_W-1:0]         last_granted_q, last_granted_d;
  logic [CH_W-1:0]         grant_ch_q, grant_ch_d;
  logic                    last_latched_q, last_latched_d;
  logic                    grant_valid_q, grant_valid_d;
  logic                    tx_req_q, tx_req_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [NUM_CHANNELS-1:0] req_ready_q, req_ready_d;

  logic                    pick_found;
  logic [CH_W-1:0]         pick_idx;
  logic                    start_grant;
  logic                    grant_ch_valid;

  rr_priority_picker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W)
  ) u_picker (
    .i_valid        (i_req_valid),
    .i_last_granted (last_granted_q),
    .o_found        (pick_found),
    .o_idx          (pick_idx)
  );

  always_comb begin
    start_grant    = (state_q == IDLE) && !i_tx_busy && pick_found;
    grant_ch_valid = i_req_valid[grant_ch_q];
  end

  always_ff @(posedge i_master_clk) begin
    if (!i_reset_n) begin
      state_q        <= IDLE;
      last_granted_q <= CH_W'(NUM_CHANNELS - 1);
      grant_ch_q     <= '0;
      last_latched_q <= 1'b0;
      grant_valid_q  <= 1'b0;
      tx_req_q       <= 1'b0;
      tx_data_q      <= 8'h00;
      req_ready_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_granted_q <= last_granted_d;
      grant_ch_q     <= grant_ch_d;
      last_latched_q <= last_latched_d;
      grant_valid_q  <= grant_valid_d;
      tx_req_q       <= tx_req_d;
      tx_data_q      <= tx_data_d;
      req_ready_q    <= req_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_grant) begin
`ifdef UART_TX_ARB_CHANNEL_ID_EN
          state_d = HEADER;
`else
          state_d = ISSUE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef UART_TX_ARB_CHANNEL_ID_EN
      HEADER:      state_d = WAIT_ACCEPT;
`endif
      ISSUE:       state_d = WAIT_ACCEPT;
      // Covers the transmitter's one-cycle busy-rise latency.
      WAIT_ACCEPT: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (last_latched_q) begin
          state_d = IDLE;
        end else if (grant_ch_valid) begin
          state_d = ISSUE;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (grant_ch_valid) begin
          state_d = ISSUE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    last_granted_d = last_granted_q;
    grant_ch_d     = grant_ch_q;
    last_latched_d = last_latched_q;
    tx_data_d      = tx_data_q;
    tx_req_d       = 1'b0;
    req_ready_d    = '0;
    grant_valid_d  = (state_d != IDLE);
    if (start_grant) begin
      last_granted_d = pick_idx;
      grant_ch_d     = pick_idx;
      last_latched_d = 1'b0;
    end else begin
      grant_ch_d     = grant_ch_q;
    end
    case (state_d)
`ifdef UART_TX_ARB_CHANNEL_ID_EN
      HEADER: begin
        tx_data_d = hdr_byte(3'(grant_ch_d));
        tx_req_d  = 1'b1;
      end
`endif
      ISSUE: begin
        tx_data_d               = 8'(i_req_data >> {grant_ch_d, 3'b000});
        tx_req_d                = 1'b1;
        req_ready_d[grant_ch_d] = 1'b1;
        last_latched_d          = i_req_last[grant_ch_d];
      end
      default: begin
        tx_req_d = 1'b0;
      end
    endcase
  end

  assign o_req_ready       = req_ready_q;
  assign o_tx_data         = tx_data_q;
  assign o_tx_data_request = tx_req_q;
  assign o_grant_valid     = grant_valid_q;
  assign o_grant_channel   = grant_ch_q;

endmodule
